br_unit_pipe: RTL and testbench

// - Parametrised, pipelined branch/jump execution unit (JAL, JALR, conditional branches) for the OoO core.
// - Sits between the branch reservation station and the CDB/writeback arbiter.
// - Buffers issued ops in an input FIFO and resolves direction and target.
// - Detects mispredicts against the frontend prediction and returns results over valid/ready handshakes.

---
 rtl/br_pkg.sv | 76 +++++++
 rtl/br_resolve.sv | 63 ++++++
 rtl/br_unit_pipe.sv | 150 +++++++++++++++
 tb/tb_br_unit_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared types for the branch execution unit.
//
// Contents:
//   XLEN, ROB_IDX_W, REG_ADDR_W : datapath widths used by the request/response structs
//   br_op_e                     : JAL, JALR or conditional branch
//   br_funct3_e                 : RV32I branch funct3 encodings
//   br_req_t                    : issued op as delivered by the branch reservation station
//   br_resp_t                   : resolved result handed to the writeback arbiter
//   branch_taken()              : evaluates a conditional branch for a given funct3
package br_pkg;

  localparam int XLEN       = 32;
  localparam int ROB_IDX_W  = 5;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    BR_JAL  = 2'd0,
    BR_JALR = 2'd1,
    BR_BR   = 2'd2
  } br_op_e;

  // RV32I branch funct3 encodings; 3'b010 and 3'b011 are undefined.
  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  typedef struct packed {
    br_op_e                  op;
    logic [2:0]              funct3;
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         imm_sext;
    logic [XLEN-1:0]         rs1_data;
    logic [XLEN-1:0]         rs2_data;
    logic [REG_ADDR_W-1:0]   rd_addr;
    logic [ROB_IDX_W-1:0]    rd_rob_idx;
    logic                    regf_we;
    logic                    pred_taken;
    logic [XLEN-1:0]         pred_target;
  } br_req_t;

  typedef struct packed {
    logic [XLEN-1:0]         pc;
    logic [REG_ADDR_W-1:0]   rd_addr;
    logic [ROB_IDX_W-1:0]    rd_rob_idx;
    logic [XLEN-1:0]         rd_data;
    logic                    regf_we;
    logic                    br_en;
    logic [XLEN-1:0]         pc_new;
    logic                    mispredict;
  } br_resp_t;

  // Funct3 is kept as raw bits so undefined encodings stay representable;
  // they simply evaluate as not taken.
  function automatic logic branch_taken(input logic [2:0]      funct3,
                                        input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
    logic taken;
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (a == b);
      F3_BNE:  taken = (a != b);
      F3_BLT:  taken = ($signed(a) <  $signed(b));
      F3_BGE:  taken = ($signed(a) >= $signed(b));
      F3_BLTU: taken = (a <  b);
      F3_BGEU: taken = (a >= b);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/br_resolve.sv
// Combinational branch resolver: direction, target, link value and
// mispredict flag for a single branch/jump request.
//
// Ports:
//   req  in  br_req_t   op to resolve
//   resp out br_resp_t  resolved result (no registers inside)
module br_resolve
  import br_pkg::*;
(
  input  br_req_t  req,
  output br_resp_t resp
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] rs1_plus_imm;
  logic [XLEN-1:0] target;
  logic            br_en;
  logic            is_jump;

  // Direction and target per op; JALR clears bit 0 of the computed address.
  always_comb begin
    pc_plus4     = req.pc + XLEN'(4);
    pc_plus_imm  = req.pc + req.imm_sext;
    rs1_plus_imm = req.rs1_data + req.imm_sext;
    target       = pc_plus_imm;
    br_en        = 1'b0;
    is_jump      = 1'b0;
    case (req.op)
      BR_JAL: begin
        br_en   = 1'b1;
        is_jump = 1'b1;
      end
      BR_JALR: begin
        br_en   = 1'b1;
        is_jump = 1'b1;
        target  = {rs1_plus_imm[XLEN-1:1], 1'b0};
      end
      BR_BR: begin
        br_en = branch_taken(req.funct3, req.rs1_data, req.rs2_data);
      end
      default: begin
        br_en = 1'b0;
      end
    endcase
  end

  // Assemble the response; a taken op with the wrong predicted target is
  // still a mispredict.
  always_comb begin
    resp            = '0;
    resp.pc         = req.pc;
    resp.rd_addr    = req.rd_addr;
    resp.rd_rob_idx = req.rd_rob_idx;
    resp.regf_we    = req.regf_we;
    resp.rd_data    = is_jump ? pc_plus4 : '0;
    resp.br_en      = br_en;
    resp.pc_new     = br_en ? target : pc_plus4;
    resp.mispredict = (br_en != req.pred_taken) |
                      (br_en & (target != req.pred_target));
  end

endmodule

// File: rtl/br_unit_pipe.sv
// Pipelined branch/jump execution unit. Issued ops are buffered in a small
// FIFO, resolved combinationally at the FIFO head and carried through an
// elastic register chain to the writeback side. A mispredicted result
// produces a redirect pulse on its output handshake.
//
// Parameters:
//   DEPTH   input FIFO entries (power of two, >= 2)
//   STAGES  result registers after resolve (1..3)
//   Data/PC and ROB index widths come from br_pkg (XLEN, ROB_IDX_W).
//
// Ports:
//   clk             clock
//   rst             asynchronous active-low reset
//   flush           synchronous kill of every in-flight op
//   in_valid/in_ready/in_req      issue handshake (in_ready = ~full & ~flush)
//   out_valid/out_ready/out_resp  result handshake
//   redirect_valid  pulse on handshake of a mispredicted result
//   redirect_pc     correct next PC, valid with redirect_valid
//
// Optional build macro BR_UNIT_STATS_EN adds saturating counters
// stat_br_cnt (results handed off) and stat_mispred_cnt (redirects issued),
// cleared only by rst.
module br_unit_pipe
  import br_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  br_req_t         in_req,
  output logic            out_valid,
  input  logic            out_ready,
  output br_resp_t        out_resp,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
`ifdef BR_UNIT_STATS_EN
  ,
  output logic [31:0]     stat_br_cnt,
  output logic [31:0]     stat_mispred_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  br_req_t           fifo_mem [DEPTH];
  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic              pop;
  br_resp_t          head_resp;

  logic [STAGES-1:0] stage_valid;
  br_resp_t          stage_data [STAGES];
  logic [STAGES-1:0] stage_load;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // No bypass: a full FIFO refuses even if it pops this cycle.
  assign in_ready = ~fifo_full & ~flush;
  assign push     = in_valid & in_ready;
  assign pop      = stage_load[0] & ~fifo_empty & ~flush;

  br_resolve u_resolve (
    .req  (fifo_mem[rd_ptr[PTR_W-1:0]]),
    .resp (head_resp)
  );

  // A stage may load whenever it or any later stage has a hole, or the
  // output is being accepted. Written without stage-to-stage feedback so the
  // ready path stays a flat reduction.
  always_comb begin
    stage_load = '0;
    for (int k = 0; k < STAGES; k++) begin
      stage_load[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!stage_valid[j]) stage_load[k] = 1'b1;
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= in_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Elastic result chain. Payload is only overwritten by a valid op so the
  // registers hold still behind a bubble and while the output is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid <= '0;
      for (int k = 0; k < STAGES; k++) stage_data[k] <= '0;
    end else if (flush) begin
      stage_valid <= '0;
    end else begin
      if (stage_load[0]) begin
        stage_valid[0] <= ~fifo_empty;
        if (!fifo_empty) stage_data[0] <= head_resp;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (stage_load[k]) begin
          stage_valid[k] <= stage_valid[k-1];
          if (stage_valid[k-1]) stage_data[k] <= stage_data[k-1];
        end
      end
    end
  end

  assign out_valid      = stage_valid[STAGES-1];
  assign out_resp       = stage_data[STAGES-1];
  assign redirect_valid = out_valid & out_ready & out_resp.mispredict;
  assign redirect_pc    = out_resp.pc_new;

`ifdef BR_UNIT_STATS_EN
  // Saturating event counters; flush does not clear them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br_cnt      <= '0;
      stat_mispred_cnt <= '0;
    end else begin
      if (out_valid && out_ready && !(&stat_br_cnt))
        stat_br_cnt <= stat_br_cnt + 32'd1;
      if (redirect_valid && !(&stat_mispred_cnt))
        stat_mispred_cnt <= stat_mispred_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_br_unit_pipe.sv
// Self-checking bench for br_unit_pipe: directed resolve cases, latency,
// back-pressure, random streams across pointer wrap, flush and mid-stream
// reset, plus the statistics counters when BR_UNIT_STATS_EN is defined.
module tb_br_unit_pipe;
  import br_pkg::*;

  localparam int DEPTH  = 4;
  localparam int STAGES = 2;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  br_req_t         in_req;
  logic            out_valid;
  logic            out_ready;
  br_resp_t        out_resp;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
`ifdef BR_UNIT_STATS_EN
  logic [31:0]     stat_br_cnt;
  logic [31:0]     stat_mispred_cnt;
`endif

  int errors = 0;
  int checks = 0;

  br_unit_pipe #(.DEPTH(DEPTH), .STAGES(STAGES)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_req         (in_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_resp       (out_resp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef BR_UNIT_STATS_EN
    ,
    .stat_br_cnt      (stat_br_cnt),
    .stat_mispred_cnt (stat_mispred_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference target straight from the ISA definition.
  function automatic logic [XLEN-1:0] ref_target(input br_req_t r);
    if (r.op == BR_JALR) return (r.rs1_data + r.imm_sext) & 32'hFFFF_FFFE;
    return r.pc + r.imm_sext;
  endfunction

  // Behavioural reference for one op.
  function automatic br_resp_t model(input br_req_t r);
    br_resp_t e;
    logic take;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] seq;
    seq  = r.pc + 32'd4;
    tgt  = ref_target(r);
    take = 1'b0;
    e    = '0;
    e.pc = r.pc;
    e.rd_addr = r.rd_addr;
    e.rd_rob_idx = r.rd_rob_idx;
    e.regf_we = r.regf_we;
    if (r.op == BR_JAL || r.op == BR_JALR) begin
      take = 1'b1;
      e.rd_data = seq;
    end else begin
      case (r.funct3)
        3'd0: take = (r.rs1_data == r.rs2_data);
        3'd1: take = (r.rs1_data != r.rs2_data);
        3'd4: take = ($signed(r.rs1_data) <  $signed(r.rs2_data));
        3'd5: take = ($signed(r.rs1_data) >= $signed(r.rs2_data));
        3'd6: take = (r.rs1_data <  r.rs2_data);
        3'd7: take = (r.rs1_data >= r.rs2_data);
        default: take = 1'b0;
      endcase
    end
    e.br_en = take;
    e.pc_new = take ? tgt : seq;
    e.mispredict = (take != r.pred_taken) || (take && (tgt != r.pred_target));
    return e;
  endfunction

  function automatic br_req_t rand_req(input int tag);
    br_req_t r;
    r = '0;
    r.op = br_op_e'($urandom_range(0, 2));
    r.funct3 = 3'($urandom_range(0, 7));
    r.pc = $urandom & 32'hFFFF_FFFC;
    r.imm_sext = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4095));
    r.rs1_data = $urandom;
    r.rs2_data = ($urandom_range(0, 3) == 0) ? r.rs1_data : $urandom;
    r.rd_addr = 5'($urandom_range(0, 31));
    r.rd_rob_idx = ROB_IDX_W'(tag);
    r.regf_we = 1'($urandom_range(0, 1));
    r.pred_taken = 1'($urandom_range(0, 1));
    r.pred_target = ($urandom_range(0, 1) == 1) ? ref_target(r) : $urandom;
    return r;
  endfunction

  // Drive one op for one cycle then wait (bounded) until a result shows up.
  task automatic issue_and_wait(input br_req_t r, output int lat);
    @(negedge clk);
    in_req = r;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_req = '0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_redirect: got %b expected 0", redirect_valid); end
    checks++; if (out_resp !== '0) begin errors++; $display("[TB] FAIL reset_out_resp: got %h expected 0", out_resp); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle: got %b expected 0", out_valid); end
  endtask

  task automatic test_beq_redirect();
    br_req_t r; int lat;
    r = '0; r.op = BR_BR; r.funct3 = 3'd0; r.pc = 32'h100; r.imm_sext = 32'h20;
    r.rs1_data = 32'd5; r.rs2_data = 32'd5; r.pred_taken = 1'b0; r.rd_rob_idx = 5'd1;
    out_ready = 1'b1;
    issue_and_wait(r, lat);
    checks++; if (lat !== STAGES + 1) begin errors++; $display("[TB] FAIL beq_latency: got %0d expected %0d", lat, STAGES + 1); end
    checks++; if (out_resp.br_en !== 1'b1) begin errors++; $display("[TB] FAIL beq_br_en: got %b expected 1", out_resp.br_en); end
    checks++; if (out_resp.pc_new !== 32'h120) begin errors++; $display("[TB] FAIL beq_pc_new: got %h expected 120", out_resp.pc_new); end
    checks++; if (out_resp.mispredict !== 1'b1) begin errors++; $display("[TB] FAIL beq_mispredict: got %b expected 1", out_resp.mispredict); end
    checks++; if (out_resp.rd_data !== 32'h0) begin errors++; $display("[TB] FAIL beq_rd_data: got %h expected 0", out_resp.rd_data); end
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL beq_redirect_valid: got %b expected 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h120) begin errors++; $display("[TB] FAIL beq_redirect_pc: got %h expected 120", redirect_pc); end
    @(negedge clk);
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL beq_redirect_pulse: got %b expected 0", redirect_valid); end
  endtask

  task automatic test_jalr();
    br_req_t r; int lat;
    r = '0; r.op = BR_JALR; r.pc = 32'h200; r.rs1_data = 32'h1003; r.imm_sext = 32'h0;
    r.pred_taken = 1'b1; r.pred_target = 32'h1002; r.rd_addr = 5'd1; r.regf_we = 1'b1;
    issue_and_wait(r, lat);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL jalr_valid: got %b expected 1", out_valid); end
    checks++; if (out_resp.pc_new !== 32'h1002) begin errors++; $display("[TB] FAIL jalr_pc_new: got %h expected 1002", out_resp.pc_new); end
    checks++; if (out_resp.rd_data !== 32'h204) begin errors++; $display("[TB] FAIL jalr_rd_data: got %h expected 204", out_resp.rd_data); end
    checks++; if (out_resp.mispredict !== 1'b0) begin errors++; $display("[TB] FAIL jalr_mispredict: got %b expected 0", out_resp.mispredict); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL jalr_redirect: got %b expected 0", redirect_valid); end
  endtask

  task automatic test_blt_bltu();
    br_req_t r; int lat;
    r = '0; r.op = BR_BR; r.funct3 = 3'd4; r.pc = 32'h300; r.imm_sext = 32'h40;
    r.rs1_data = 32'hFFFF_FFFF; r.rs2_data = 32'h1; r.pred_taken = 1'b1; r.pred_target = 32'h340;
    issue_and_wait(r, lat);
    checks++; if (out_resp.br_en !== 1'b1) begin errors++; $display("[TB] FAIL blt_br_en: got %b expected 1", out_resp.br_en); end
    checks++; if (out_resp.pc_new !== 32'h340) begin errors++; $display("[TB] FAIL blt_pc_new: got %h expected 340", out_resp.pc_new); end
    r.funct3 = 3'd6;
    issue_and_wait(r, lat);
    checks++; if (out_resp.br_en !== 1'b0) begin errors++; $display("[TB] FAIL bltu_br_en: got %b expected 0", out_resp.br_en); end
    checks++; if (out_resp.pc_new !== 32'h304) begin errors++; $display("[TB] FAIL bltu_pc_new: got %h expected 304", out_resp.pc_new); end
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304) begin errors++; $display("[TB] FAIL bltu_redirect: got %b/%h expected 1/304", redirect_valid, redirect_pc); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    br_resp_t exp_q[$]; br_resp_t e; br_req_t r; int acc; int cyc; int got; int extra;
    acc = 0; cyc = 0; got = 0; extra = 0;
    out_ready = 1'b0;
    while (acc < DEPTH + STAGES && cyc < 40) begin
      @(negedge clk);
      r = rand_req(acc); in_req = r; in_valid = 1'b1;
      #1;
      if (in_ready) begin exp_q.push_back(model(r)); acc++; end
      cyc++;
    end
    @(negedge clk);
    in_req = rand_req(31); in_valid = 1'b1;
    #1;
    checks++; if (acc !== DEPTH + STAGES) begin errors++; $display("[TB] FAIL bp_accepted: got %0d expected %0d", acc, DEPTH + STAGES); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready: got %b expected 0", in_ready); end
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready_hold: got %b expected 0", in_ready); end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while (got < acc && cyc < 40) begin
      #1;
      if (out_valid) begin
        e = exp_q.pop_front();
        checks++; if (out_resp !== e) begin errors++; $display("[TB] FAIL bp_result%0d: got %h expected %h", got, out_resp, e); end
        checks++; if (redirect_valid !== e.mispredict) begin errors++; $display("[TB] FAIL bp_redirect%0d: got %b expected %b", got, redirect_valid, e.mispredict); end
        got++;
      end
      @(negedge clk); cyc++;
    end
    checks++; if (got !== acc) begin errors++; $display("[TB] FAIL bp_drained: got %0d expected %0d", got, acc); end
    repeat (3) begin #1; if (out_valid) extra++; @(negedge clk); end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL bp_no_extra: got %0d expected 0", extra); end
  endtask

  task automatic test_stream(input int n, input int ready_pct, input int valid_pct, input string name);
    br_resp_t exp_q[$]; br_resp_t e; br_resp_t held; br_req_t r;
    int sent; int got; int cyc; logic stalled;
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0; r = '0;
    in_valid = 1'b0;
    while ((sent < n || got < n) && cyc < 4000) begin
      @(negedge clk); cyc++;
      if (stalled) begin
        checks++; if (out_valid !== 1'b1 || out_resp !== held) begin errors++; $display("[TB] FAIL %s_hold: got %b/%h expected 1/%h", name, out_valid, out_resp, held); end
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (sent < n && $urandom_range(0, 99) < valid_pct) begin
        r = rand_req(sent); in_req = r; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("[TB] FAIL %s_unexpected: got %h expected none", name, out_resp);
        end else begin
          e = exp_q.pop_front();
          checks++; if (out_resp !== e) begin errors++; $display("[TB] FAIL %s_result%0d: got %h expected %h", name, got, out_resp, e); end
          checks++; if (redirect_valid !== e.mispredict || (e.mispredict && redirect_pc !== e.pc_new)) begin
            errors++; $display("[TB] FAIL %s_redirect%0d: got %b/%h expected %b/%h", name, got, redirect_valid, redirect_pc, e.mispredict, e.pc_new); end
        end
        got++;
      end else begin
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s_redirect_idle: got %b expected 0", name, redirect_valid); end
      end
      stalled = out_valid && !out_ready;
      held = out_resp;
      if (in_valid && in_ready) begin exp_q.push_back(model(r)); sent++; end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got !== n) begin errors++; $display("[TB] FAIL %s_count: got %0d expected %0d", name, got, n); end
  endtask

  task automatic test_flush();
    br_req_t r; int cyc; int extra; int lat; br_resp_t e;
    cyc = 0; extra = 0;
    out_ready = 1'b0;
    while (cyc < 20) begin
      @(negedge clk);
      in_req = rand_req(cyc); in_valid = 1'b1;
      cyc++;
    end
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_prefill: got %b/%b expected 0/1", in_ready, out_valid); end
    @(negedge clk);
    flush = 1'b1; in_req = rand_req(30); in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready_after: got %b expected 1", in_ready); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_redirect: got %b expected 0", redirect_valid); end
    out_ready = 1'b1;
    repeat (5) begin @(negedge clk); if (out_valid) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL flush_dropped: got %0d results expected 0", extra); end
    r = rand_req(7);
    e = model(r);
    issue_and_wait(r, lat);
    checks++; if (out_resp !== e || lat !== STAGES + 1) begin errors++; $display("[TB] FAIL flush_recover: got %h lat %0d expected %h lat %0d", out_resp, lat, e, STAGES + 1); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc; int extra;
    cyc = 0; extra = 0;
    out_ready = 1'b0;
    repeat (3) begin @(negedge clk); in_req = rand_req(cyc); in_valid = 1'b1; cyc++; end
    @(negedge clk); in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_prefill: got %b expected 1", out_valid); end
    out_ready = 1'b1;
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_valid: got %b/%b expected 0/0", out_valid, redirect_valid); end
    checks++; if (out_resp !== '0) begin errors++; $display("[TB] FAIL rstmid_resp: got %h expected 0", out_resp); end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) begin @(negedge clk); if (out_valid) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL rstmid_lost: got %0d results expected 0", extra); end
  endtask

`ifdef BR_UNIT_STATS_EN
  task automatic test_stats();
    br_req_t r; int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      r = '0; r.op = BR_JAL; r.pc = 32'h1000 + 32'(i * 4); r.imm_sext = 32'h80;
      r.pred_taken = (i % 3 != 0) || (i == 9);
      r.pred_target = r.pc + 32'h80;
      issue_and_wait(r, lat);
    end
    @(negedge clk);
    checks++; if (stat_br_cnt !== 32'd10) begin errors++; $display("[TB] FAIL stats_br_cnt: got %0d expected 10", stat_br_cnt); end
    checks++; if (stat_mispred_cnt !== 32'd3) begin errors++; $display("[TB] FAIL stats_mispred_cnt: got %0d expected 3", stat_mispred_cnt); end
  endtask
`endif

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_beq_redirect();
    test_jalr();
    test_blt_bltu();
    test_backpressure();
    test_stream(3 * DEPTH + 4, 100, 100, "back_to_back");
    test_stream(60, 60, 70, "random");
    test_flush();
    test_reset_mid();
`ifdef BR_UNIT_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
